// File: rtl/rbport_if.sv
// Register-bus port bundle: request, bank-side access and response channels.
interface rbport_if #(
  parameter int unsigned DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic [6:0]    req_r;
  logic          req_we;
  logic [DW-1:0] req_wdata;

  logic          bank_req;
  logic [17:0]   bank_sel;
  logic [3:0]    bank_off;
  logic          bank_we;
  logic [DW-1:0] bank_wdata;
  logic          bank_ack;
  logic [DW-1:0] bank_rdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  // Port block's view.
  modport slave (
    input  req_valid, req_r, req_we, req_wdata, bank_ack, bank_rdata, rsp_ready,
    output req_ready, bank_req, bank_sel, bank_off, bank_we, bank_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );

  // Requester/bank/consumer environment's view.
  modport master (
    output req_valid, req_r, req_we, req_wdata, bank_ack, bank_rdata, rsp_ready,
    input  req_ready, bank_req, bank_sel, bank_off, bank_we, bank_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rbport.sv
// Single-outstanding register-bus port: decodes a 7-bit address into one of 18
// register spaces, runs one bank access with timeout, and returns a response.
module rbport #(
  parameter int unsigned DW  = 16,
  parameter int unsigned TMO = 15
) (
  input  logic       clk,
  input  logic       rst,
  rbport_if.slave    bus,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] TmoCnt = 8'(TMO);

  typedef enum logic [1:0] {StIdle, StBank, StResp} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q;
  logic          bank_req_q;
  logic [17:0]   bank_sel_q;
  logic [3:0]    bank_off_q;
  logic          bank_we_q;
  logic [DW-1:0] bank_wdata_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          rsp_err_q;
  logic [7:0]    err_cnt_q;

  logic [17:0]   dec_sel;
  logic [3:0]    dec_off;
  logic          accept;
  logic          timeout;

  assign accept  = bus.req_valid && (state_q == StIdle);
  assign timeout = (cnt_q == TmoCnt);

  // Address decode into one-hot space select and in-space offset.
  always_comb begin
    dec_sel = '0;
    dec_off = '0;
    if (bus.req_r[6:4] == 3'h0) begin
      dec_sel[0] = 1'b1;
      dec_off    = bus.req_r[3:0];
    end else if (bus.req_r[6:4] == 3'h1) begin
      dec_sel[1] = 1'b1;
      dec_off    = bus.req_r[3:0];
    end else if (bus.req_r[6:3] == 4'h4) begin
      dec_sel[2] = 1'b1;
      dec_off    = {1'b0, bus.req_r[2:0]};
    end else if (bus.req_r[6:3] == 4'h5) begin
      dec_sel[3] = 1'b1;
      dec_off    = {1'b0, bus.req_r[2:0]};
    end else if (bus.req_r[6:3] == 4'h6) begin
      dec_sel[4] = 1'b1;
      dec_off    = {1'b0, bus.req_r[2:0]};
    end else if (bus.req_r[6:3] == 4'h7) begin
      dec_sel[5] = 1'b1;
      dec_off    = {1'b0, bus.req_r[2:0]};
    end else if (bus.req_r[6:4] == 3'h4) begin
      dec_sel[6] = 1'b1;
      dec_off    = bus.req_r[3:0];
    end else if (bus.req_r[6:4] == 3'h5) begin
      dec_sel[7] = 1'b1;
      dec_off    = bus.req_r[3:0];
    end else if (bus.req_r[6:2] == 5'h18) begin
      dec_sel[8] = 1'b1;
      dec_off    = {2'b00, bus.req_r[1:0]};
    end else if (bus.req_r[6:2] == 5'h19) begin
      dec_sel[9] = 1'b1;
      dec_off    = {2'b00, bus.req_r[1:0]};
    end else if (bus.req_r[6:3] == 4'hD) begin
      // Single-register spaces 0x68..0x6F map to bits 10..17.
      dec_sel[5'd10 + {2'b00, bus.req_r[2:0]}] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; an ack on the timeout cycle still completes normally.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.req_valid) state_d = (dec_sel != '0) ? StBank : StResp;
      StBank: if (bus.bank_ack || timeout) state_d = StResp;
      StResp: if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-decoded handshake outputs.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      StIdle:  bus.req_ready = 1'b1;
      StResp:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture, bank-access, response and error-count datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      bank_req_q   <= 1'b0;
      bank_sel_q   <= '0;
      bank_off_q   <= '0;
      bank_we_q    <= 1'b0;
      bank_wdata_q <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q <= '0;
            if (dec_sel != '0) begin
              bank_req_q   <= 1'b1;
              bank_sel_q   <= dec_sel;
              bank_off_q   <= dec_off;
              bank_we_q    <= bus.req_we;
              bank_wdata_q <= bus.req_wdata;
            end else begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        StBank: begin
          if (bus.bank_ack) begin
            bank_req_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= bank_we_q ? '0 : bus.bank_rdata;
          end else if (timeout) begin
            bank_req_q  <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          if (bus.rsp_ready && rsp_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bank_req   = bank_req_q;
  assign bus.bank_sel   = bank_sel_q;
  assign bus.bank_off   = bank_off_q;
  assign bus.bank_we    = bank_we_q;
  assign bus.bank_wdata = bank_wdata_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign err_cnt        = err_cnt_q;

endmodule
